// File: rtl/uart_rx_ctrl_if.sv
// Downstream frame stream of uart_rx_ctrl.
//   m_data  : 9-bit frame at the head of the FIFO
//   m_valid : head entry present
//   m_ready : consumer accepts the head entry this cycle
interface uart_rx_ctrl_if;
  logic [8:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// Control and buffering companion for a UART receiver on the 16x-baud clock.
// Holds the receiver frame configuration, defers a new configuration until
// the line has been quiet for IDLE_GAP samples, and buffers received frames
// in a DEPTH-entry FIFO with sticky overflow and a saturating drop counter.
// Ports:
//   clk_16bd, rst          : clock, synchronous active-high reset
//   Rx                     : serial line (idle detection)
//   rx_en                  : 1 = store received frames, 0 = discard
//   cfg_wr, cfg_*          : configuration write strobe and fields
//   rx_frame(_valid)       : receiver output frame and its valid level
//   rx_rst                 : one-cycle receiver reset while a config is applied
//   rx_parity.. rx_frame_length : active configuration
//   cfg_busy, cfg_err      : config pending / illegal write pulse
//   ovf, ovf_cnt           : sticky overflow, saturating drop count
//   m_if                   : downstream ready/valid stream (master side)
module uart_rx_ctrl #(
  parameter int DEPTH    = 4,
  parameter int IDLE_GAP = 32
) (
  input  logic       clk_16bd,
  input  logic       rst,
  input  logic       Rx,
  input  logic       rx_en,
  input  logic       cfg_wr,
  input  logic       cfg_parity,
  input  logic       cfg_parity_type,
  input  logic       cfg_stop_bits,
  input  logic [3:0] cfg_frame_length,
  input  logic [8:0] rx_frame,
  input  logic       rx_frame_valid,
  output logic       rx_rst,
  output logic       rx_parity,
  output logic       rx_parity_type,
  output logic       rx_stop_bits,
  output logic [3:0] rx_frame_length,
  output logic       cfg_busy,
  output logic       cfg_err,
  output logic       ovf,
  output logic [7:0] ovf_cnt,
  uart_rx_ctrl_if.master m_if
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {RUN, PEND, APPLY} state_t;

  state_t      state_q, state_d;
  logic [7:0]  idle_cnt_q;
  logic        sh_parity_q, sh_parity_type_q, sh_stop_bits_q;
  logic [3:0]  sh_frame_length_q;
  logic        rx_parity_q, rx_parity_type_q, rx_stop_bits_q;
  logic [3:0]  rx_frame_length_q;
  logic        rx_rst_q, cfg_busy_q, cfg_err_q;
  logic        fv_q;
  logic [8:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [8:0]  m_data_q, head_d;
  logic        m_valid_q;
  logic        ovf_q;
  logic [7:0]  ovf_cnt_q;

  logic        cfg_legal, idle_full, push, pop, full, push_ok, drop;
  logic [8:0]  frame_mask, wr_data;

  assign cfg_legal = cfg_wr && (cfg_frame_length >= 4'd5) && (cfg_frame_length <= 4'd9);
  assign idle_full = (idle_cnt_q == 8'(IDLE_GAP));

  // Bits beyond the active frame length are forced to zero.
  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_mask
      assign frame_mask[gi] = (4'(gi) < rx_frame_length_q);
    end
  endgenerate
  assign wr_data = rx_frame & frame_mask;

  // Only the rising edge of frame_valid is a new frame; frames arriving while
  // the receiver is being reset are not trusted.
  assign push    = rx_frame_valid && !fv_q && rx_en && (state_q != APPLY);
  assign pop     = m_valid_q && m_if.m_ready;
  assign full    = (count_q == CW'(DEPTH));
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (cfg_legal) state_d = PEND;
      PEND:    if (!cfg_legal && idle_full) state_d = APPLY;
      APPLY:   state_d = cfg_legal ? PEND : RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    count_d  = count_q + CW'(push_ok) - CW'(pop);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    // When the FIFO drains to empty in the same cycle a frame is written, the
    // new head is the incoming word rather than the (not yet written) RAM.
    if (push_ok && ((count_q - CW'(pop)) == '0)) head_d = wr_data;
    else                                         head_d = mem[rd_ptr_d];
  end

  always_ff @(posedge clk_16bd) begin
    if (push_ok) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk_16bd) begin
    if (rst) begin
      state_q           <= RUN;
      idle_cnt_q        <= '0;
      sh_parity_q       <= 1'b0;
      sh_parity_type_q  <= 1'b0;
      sh_stop_bits_q    <= 1'b0;
      sh_frame_length_q <= 4'd8;
      rx_parity_q       <= 1'b0;
      rx_parity_type_q  <= 1'b0;
      rx_stop_bits_q    <= 1'b0;
      rx_frame_length_q <= 4'd8;
      rx_rst_q          <= 1'b0;
      cfg_busy_q        <= 1'b0;
      cfg_err_q         <= 1'b0;
      fv_q              <= 1'b0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      m_data_q          <= '0;
      m_valid_q         <= 1'b0;
      ovf_q             <= 1'b0;
      ovf_cnt_q         <= '0;
    end else begin
      state_q    <= state_d;
      rx_rst_q   <= (state_d == APPLY);
      cfg_busy_q <= (state_d != RUN);
      cfg_err_q  <= cfg_wr && !cfg_legal;
      fv_q       <= rx_frame_valid;

      if (!Rx)            idle_cnt_q <= '0;
      else if (!idle_full) idle_cnt_q <= idle_cnt_q + 8'd1;

      if (cfg_legal) begin
        sh_parity_q       <= cfg_parity;
        sh_parity_type_q  <= cfg_parity_type;
        sh_stop_bits_q    <= cfg_stop_bits;
        sh_frame_length_q <= cfg_frame_length;
      end
      if (state_q == APPLY) begin
        rx_parity_q       <= sh_parity_q;
        rx_parity_type_q  <= sh_parity_type_q;
        rx_stop_bits_q    <= sh_stop_bits_q;
        rx_frame_length_q <= sh_frame_length_q;
      end

      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      m_valid_q <= (count_d != '0);
      if (count_d != '0) m_data_q <= head_d;

      if (drop) begin
        ovf_q <= 1'b1;
        if (ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
      end
    end
  end

  assign rx_rst          = rx_rst_q;
  assign rx_parity       = rx_parity_q;
  assign rx_parity_type  = rx_parity_type_q;
  assign rx_stop_bits    = rx_stop_bits_q;
  assign rx_frame_length = rx_frame_length_q;
  assign cfg_busy        = cfg_busy_q;
  assign cfg_err         = cfg_err_q;
  assign ovf             = ovf_q;
  assign ovf_cnt         = ovf_cnt_q;
  assign m_if.m_data     = m_data_q;
  assign m_if.m_valid    = m_valid_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed stimulus, a transaction-level model
// (frame queue, quiet-run length, pending/applying flags) compared against
// the DUT on every falling edge, plus literal expectations that pin the model.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 4;
  localparam int GAP   = 32;

  logic       clk = 1'b0;
  logic       rst, Rx, rx_en, cfg_wr, cfg_parity, cfg_parity_type, cfg_stop_bits;
  logic [3:0] cfg_frame_length;
  logic [8:0] rx_frame;
  logic       rx_frame_valid, m_ready;
  logic       rx_rst, rx_parity, rx_parity_type, rx_stop_bits, cfg_busy, cfg_err, ovf;
  logic [3:0] rx_frame_length;
  logic [7:0] ovf_cnt;

  uart_rx_ctrl_if m_if ();
  assign m_if.m_ready = m_ready;

  uart_rx_ctrl #(.DEPTH(DEPTH), .IDLE_GAP(GAP)) dut (
    .clk_16bd(clk), .rst(rst), .Rx(Rx), .rx_en(rx_en), .cfg_wr(cfg_wr),
    .cfg_parity(cfg_parity), .cfg_parity_type(cfg_parity_type),
    .cfg_stop_bits(cfg_stop_bits), .cfg_frame_length(cfg_frame_length),
    .rx_frame(rx_frame), .rx_frame_valid(rx_frame_valid), .rx_rst(rx_rst),
    .rx_parity(rx_parity), .rx_parity_type(rx_parity_type),
    .rx_stop_bits(rx_stop_bits), .rx_frame_length(rx_frame_length),
    .cfg_busy(cfg_busy), .cfg_err(cfg_err), .ovf(ovf), .ovf_cnt(ovf_cnt),
    .m_if(m_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state
  int q[$];
  bit e_valid, e_ovf, e_rst, e_busy, e_err, pending, applying, fv_prev;
  int e_data, e_ovf_cnt, quiet;
  int sh_len, sh_par, sh_pt, sh_sb, a_len, a_par, a_pt, a_sb;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit pop, push, legal, nxt_apply;
    int d;
    if (rst) begin
      q.delete();
      e_valid = 0; e_data = 0; e_ovf = 0; e_ovf_cnt = 0; e_rst = 0; e_busy = 0; e_err = 0;
      pending = 0; applying = 0; fv_prev = 0; quiet = 0;
      sh_len = 8; sh_par = 0; sh_pt = 0; sh_sb = 0;
      a_len = 8; a_par = 0; a_pt = 0; a_sb = 0;
      return;
    end
    pop   = e_valid && m_ready;
    push  = rx_frame_valid && !fv_prev && rx_en && !applying;
    legal = cfg_wr && cfg_frame_length >= 5 && cfg_frame_length <= 9;
    if (pop) begin
      $display("pop  data=0x%03h", q[0]);
      void'(q.pop_front());
    end
    if (push) begin
      d = int'(rx_frame) & ((1 << a_len) - 1);
      if (q.size() < DEPTH) begin
        q.push_back(d);
        $display("push data=0x%03h", d);
      end else begin
        e_ovf = 1;
        if (e_ovf_cnt < 255) e_ovf_cnt++;
        $display("drop data=0x%03h", d);
      end
    end
    fv_prev = rx_frame_valid;
    if (applying) begin
      a_len = sh_len; a_par = sh_par; a_pt = sh_pt; a_sb = sh_sb;
    end
    nxt_apply = 0;
    if (legal) begin
      sh_len = cfg_frame_length; sh_par = cfg_parity; sh_pt = cfg_parity_type; sh_sb = cfg_stop_bits;
      pending = 1;
    end else if (pending && quiet == GAP) begin
      pending = 0;
      nxt_apply = 1;
    end
    applying = nxt_apply;
    e_rst  = applying;
    e_busy = pending || applying;
    e_err  = cfg_wr && !legal;
    quiet  = Rx ? ((quiet < GAP) ? quiet + 1 : GAP) : 0;
    e_valid = (q.size() != 0);
    if (e_valid) e_data = q[0];
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  // Compare process: DUT against model on every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", int'(m_if.m_valid), int'(e_valid));
      if (e_valid) chk("m_data", int'(m_if.m_data), e_data);
      chk("ovf", int'(ovf), int'(e_ovf));
      chk("ovf_cnt", int'(ovf_cnt), e_ovf_cnt);
      chk("rx_rst", int'(rx_rst), int'(e_rst));
      chk("cfg_busy", int'(cfg_busy), int'(e_busy));
      chk("cfg_err", int'(cfg_err), int'(e_err));
      chk("rx_frame_length", int'(rx_frame_length), a_len);
      chk("rx_parity", int'(rx_parity), a_par);
      chk("rx_parity_type", int'(rx_parity_type), a_pt);
      chk("rx_stop_bits", int'(rx_stop_bits), a_sb);
    end
  end

  task automatic pulse(input logic [8:0] f);
    rx_frame = f; rx_frame_valid = 1'b1; step();
    rx_frame_valid = 1'b0; step();
  endtask

  task automatic cfg(input logic [3:0] len, input logic par);
    cfg_wr = 1'b1; cfg_frame_length = len; cfg_parity = par;
    cfg_parity_type = 1'b0; cfg_stop_bits = 1'b0;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic wait_apply(input string name);
    for (int k = 0; k < 80 && !rx_rst; k++) step();
    chk(name, int'(rx_rst), 1);
  endtask

  logic [8:0] drainv [4];

  initial begin
    rst = 1'b1; Rx = 1'b1; rx_en = 1'b1; cfg_wr = 1'b0; cfg_parity = 1'b0;
    cfg_parity_type = 1'b0; cfg_stop_bits = 1'b0; cfg_frame_length = 4'd8;
    rx_frame = '0; rx_frame_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    repeat (3) step();
    chk("reset_len", int'(rx_frame_length), 8);
    chk("reset_m_valid", int'(m_if.m_valid), 0);
    chk("reset_m_data", int'(m_if.m_data), 0);
    chk("reset_ovf_cnt", int'(ovf_cnt), 0);
    rst = 1'b0;
    step();

    // Single frame, valid level held three cycles -> one entry.
    rx_frame = 9'h1A5; rx_frame_valid = 1'b1;
    step();
    chk("t1_m_valid", int'(m_if.m_valid), 1);
    chk("t1_m_data", int'(m_if.m_data), 9'h0A5);
    step(); step();
    rx_frame_valid = 1'b0; step();
    chk("t1_model_count", q.size(), 1);
    m_ready = 1'b1; step();
    m_ready = 1'b0;
    chk("t1_drained", int'(m_if.m_valid), 0);

    // Config deferred while Rx toggles, applied after a quiet run.
    cfg(4'd7, 1'b1);
    for (int i = 0; i < 20; i++) begin
      Rx = (i % 3) != 0;
      step();
    end
    chk("t2_busy_hold", int'(cfg_busy), 1);
    chk("t2_len_hold", int'(rx_frame_length), 8);
    Rx = 1'b1;
    wait_apply("t2_apply_seen");
    step();
    chk("t2_len_new", int'(rx_frame_length), 7);
    chk("t2_parity_new", int'(rx_parity), 1);
    chk("t2_busy_clear", int'(cfg_busy), 0);
    chk("t2_rst_clear", int'(rx_rst), 0);

    // Illegal config lengths.
    cfg(4'd4, 1'b0);
    chk("t3_err4", int'(cfg_err), 1);
    step();
    chk("t3_err4_clear", int'(cfg_err), 0);
    cfg(4'd10, 1'b0);
    chk("t3_err10", int'(cfg_err), 1);
    step();
    chk("t3_busy", int'(cfg_busy), 0);
    chk("t3_len", int'(rx_frame_length), 7);

    // Overflow: six frames into a four-entry FIFO, 7-bit frames.
    pulse(9'h1F1); pulse(9'h0E2); pulse(9'h1D3);
    pulse(9'h0C4); pulse(9'h1B5); pulse(9'h0A6);
    chk("t4_ovf", int'(ovf), 1);
    chk("t4_ovf_cnt", int'(ovf_cnt), 2);
    chk("t4_head", int'(m_if.m_data), 9'h071);
    // Full with push and pop together.
    rx_frame = 9'h1FF; rx_frame_valid = 1'b1; m_ready = 1'b1;
    step();
    rx_frame_valid = 1'b0; m_ready = 1'b0;
    chk("t4_model_count", q.size(), 4);
    chk("t4_ovf_cnt_same", int'(ovf_cnt), 2);
    drainv[0] = 9'h062; drainv[1] = 9'h053; drainv[2] = 9'h044; drainv[3] = 9'h07F;
    step();
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t4_drain", int'(m_if.m_data), int'(drainv[k]));
      step();
    end
    m_ready = 1'b0;
    chk("t4_empty", int'(m_if.m_valid), 0);

    // Fresh reset: rx_en=0 discards; frame edge in APPLY cycle is ignored.
    rst = 1'b1; step(); step(); rst = 1'b0;
    rx_en = 1'b0;
    pulse(9'h011); pulse(9'h022); pulse(9'h033);
    chk("t5_discard", int'(m_if.m_valid), 0);
    chk("t5_ovf_cnt", int'(ovf_cnt), 0);
    rx_en = 1'b1;
    cfg(4'd6, 1'b0);
    wait_apply("t5_apply_seen");
    rx_frame = 9'h155; rx_frame_valid = 1'b1;
    step(); step();
    rx_frame_valid = 1'b0; step();
    chk("t5_apply_drop", int'(m_if.m_valid), 0);
    chk("t5_len", int'(rx_frame_length), 6);
    pulse(9'h155);
    chk("t5_after_push", int'(m_if.m_valid), 1);
    chk("t5_after_data", int'(m_if.m_data), 9'h015);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
